// File: rtl/sys_mem_burst_slave_if.sv
// Burst channel bundle between the L1 cache (master) and the backing memory (slave).
// Carries request, write-beat and read-beat handshakes plus status flags.
// Clock and reset are kept outside as plain ports of the endpoints.
interface sys_mem_burst_slave_if #(
    parameter int DATA_WIDTH      = 32,
    parameter int DATA_ADDR_WIDTH = 32
);
    logic                       req_valid;
    logic                       req_ready;
    logic                       req_write;
    logic [DATA_ADDR_WIDTH-1:0] req_addr;
    logic                       wdata_valid;
    logic                       wdata_ready;
    logic [DATA_WIDTH-1:0]      wdata;
    logic                       wdata_last;
    logic                       rdata_valid;
    logic                       rdata_ready;
    logic [DATA_WIDTH-1:0]      rdata;
    logic                       rdata_last;
    logic                       wr_done;
    logic                       proto_err;

    modport slave (
        input  req_valid, req_write, req_addr, wdata_valid, wdata, wdata_last, rdata_ready,
        output req_ready, wdata_ready, rdata_valid, rdata, rdata_last, wr_done, proto_err
    );

    modport master (
        output req_valid, req_write, req_addr, wdata_valid, wdata, wdata_last, rdata_ready,
        input  req_ready, wdata_ready, rdata_valid, rdata, rdata_last, wr_done, proto_err
    );
endinterface

// File: rtl/sys_mem_burst_slave.sv
// Backing memory serving fixed-length line-aligned read and write bursts, one at a time.
// Latency: first read beat READ_LATENCY+1 cycles after the accept edge; write beats stored on their handshake edge.
// Backpressure: read beats hold until rdata_ready; wdata_ready stays high for the whole write burst.
module sys_mem_burst_slave #(
    parameter int DATA_WIDTH      = 32,
    parameter int DATA_ADDR_WIDTH = 32,
    parameter int NUM_WORDS       = 1024,
    parameter int READ_BURST_LEN  = 8,
    parameter int WRITE_BURST_LEN = 8,
    parameter int READ_LATENCY    = 4
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst_n,
    sys_mem_burst_slave_if.slave  bus
);
    localparam int IDX_W     = $clog2(NUM_WORDS);
    localparam int MAX_BURST = (READ_BURST_LEN > WRITE_BURST_LEN) ? READ_BURST_LEN : WRITE_BURST_LEN;
    localparam int BEAT_W    = $clog2(MAX_BURST) + 1;
    localparam int LAT_W     = $clog2(READ_LATENCY + 1);

    // Masks that clear the in-line word offset so each burst starts on a line boundary.
    localparam logic [IDX_W-1:0] RD_ALIGN = ~IDX_W'(READ_BURST_LEN - 1);
    localparam logic [IDX_W-1:0] WR_ALIGN = ~IDX_W'(WRITE_BURST_LEN - 1);

    typedef enum logic [2:0] {
        IDLE,
        RD_WAIT,
        RD_BURST,
        WR_BURST,
        WR_DONE
    } state_t;

    state_t                 state_q;
    logic [IDX_W-1:0]       idx_q;
    logic [BEAT_W-1:0]      beat_q;
    logic [LAT_W-1:0]       lat_q;
    logic                   req_ready_q;
    logic                   wdata_ready_q;
    logic                   rdata_valid_q;
    logic                   rdata_last_q;
    logic                   wr_done_q;
    logic                   proto_err_q;

    logic [DATA_WIDTH-1:0]  mem [NUM_WORDS];

    logic [IDX_W-1:0]       word_idx;
    logic [IDX_W-1:0]       rd_base_d;
    logic [IDX_W-1:0]       wr_base_d;
    logic [IDX_W-1:0]       idx_inc_d;
    logic [BEAT_W-1:0]      beat_inc_d;
    logic [LAT_W-1:0]       lat_inc_d;
    logic                   req_fire;
    logic                   wr_fire;
    logic                   rd_fire;
    logic                   wr_is_last;
    logic                   rd_is_last;
    logic                   unused_addr_bits;

    // Byte address -> word index; upper bits alias modulo NUM_WORDS and byte offset is dropped.
    assign word_idx   = bus.req_addr[IDX_W+1:2];
    assign rd_base_d  = word_idx & RD_ALIGN;
    assign wr_base_d  = word_idx & WR_ALIGN;
    assign idx_inc_d  = idx_q + 1'b1;
    assign beat_inc_d = beat_q + 1'b1;
    assign lat_inc_d  = lat_q + 1'b1;

    assign unused_addr_bits = ^{bus.req_addr[DATA_ADDR_WIDTH-1:IDX_W+2], bus.req_addr[1:0]};

    // The ready/valid registers are only ever high in their owning state.
    assign req_fire   = bus.req_valid   && req_ready_q;
    assign wr_fire    = bus.wdata_valid && wdata_ready_q;
    assign rd_fire    = bus.rdata_ready && rdata_valid_q;
    assign wr_is_last = (beat_q == BEAT_W'(WRITE_BURST_LEN - 1));
    assign rd_is_last = (beat_q == BEAT_W'(READ_BURST_LEN - 1));

    assign bus.req_ready   = req_ready_q;
    assign bus.wdata_ready = wdata_ready_q;
    assign bus.rdata_valid = rdata_valid_q;
    assign bus.rdata_last  = rdata_last_q;
    assign bus.wr_done     = wr_done_q;
    assign bus.proto_err   = proto_err_q;
    // Read data comes straight from the registered beat index; forced to zero outside a read beat.
    assign bus.rdata       = rdata_valid_q ? mem[idx_q] : '0;

    // Storage array: written on write-beat handshakes, deliberately not reset so contents survive reset.
    always_ff @(posedge sys_clk) begin
        if (wr_fire) begin
            mem[idx_q] <= bus.wdata;
        end
    end

    // Burst sequencer with all handshake and status outputs registered.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q       <= IDLE;
            idx_q         <= '0;
            beat_q        <= '0;
            lat_q         <= '0;
            req_ready_q   <= 1'b0;
            wdata_ready_q <= 1'b0;
            rdata_valid_q <= 1'b0;
            rdata_last_q  <= 1'b0;
            wr_done_q     <= 1'b0;
            proto_err_q   <= 1'b0;
        end else begin
            wr_done_q <= 1'b0;
            // A last marker that disagrees with the beat count is flagged but never shortens the burst.
            if (wr_fire && (bus.wdata_last != wr_is_last)) begin
                proto_err_q <= 1'b1;
            end
            unique case (state_q)
                IDLE: begin
                    req_ready_q <= 1'b1;
                    if (req_fire) begin
                        req_ready_q <= 1'b0;
                        beat_q      <= '0;
                        lat_q       <= '0;
                        if (bus.req_write) begin
                            idx_q         <= wr_base_d;
                            wdata_ready_q <= 1'b1;
                            state_q       <= WR_BURST;
                        end else begin
                            idx_q   <= rd_base_d;
                            state_q <= RD_WAIT;
                        end
                    end
                end
                RD_WAIT: begin
                    if (lat_q == LAT_W'(READ_LATENCY)) begin
                        state_q       <= RD_BURST;
                        rdata_valid_q <= 1'b1;
                        rdata_last_q  <= (READ_BURST_LEN == 1);
                    end else begin
                        lat_q <= lat_inc_d;
                    end
                end
                RD_BURST: begin
                    if (rd_fire) begin
                        if (rd_is_last) begin
                            state_q       <= IDLE;
                            rdata_valid_q <= 1'b0;
                            rdata_last_q  <= 1'b0;
                            req_ready_q   <= 1'b1;
                        end else begin
                            beat_q       <= beat_inc_d;
                            idx_q        <= idx_inc_d;
                            rdata_last_q <= (beat_inc_d == BEAT_W'(READ_BURST_LEN - 1));
                        end
                    end
                end
                WR_BURST: begin
                    if (wr_fire) begin
                        if (wr_is_last) begin
                            state_q       <= WR_DONE;
                            wdata_ready_q <= 1'b0;
                            wr_done_q     <= 1'b1;
                        end else begin
                            beat_q <= beat_inc_d;
                            idx_q  <= idx_inc_d;
                        end
                    end
                end
                WR_DONE: begin
                    state_q     <= IDLE;
                    req_ready_q <= 1'b1;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: doc/sys_mem_burst_slave.md
Name: sys_mem_burst_slave

Overview:
- System-side backing memory on sys_clk. Services the L1 cache's line refills (read bursts) and write-backs (write bursts) over a valid/ready burst interface.
- Sits directly downstream of the cache inside chip and is the terminal storage of the memory hierarchy.
- Fixed-length, line-aligned bursts with configurable first-beat read latency.

Parameters:
DATA_WIDTH, 32, beat/word width in bits
DATA_ADDR_WIDTH, 32, byte address width
NUM_WORDS, 1024, memory depth in words (power of 2)
READ_BURST_LEN, 8, beats per read burst (power of 2)
WRITE_BURST_LEN, 8, beats per write burst (power of 2)
READ_LATENCY, 4, idle cycles between request accept and first read beat (>=1)

Ports:
sys_clk  in  1  system clock, all logic on rising edge
sys_rst_n  in  1  reset, asynchronous, active-low
req_valid  in  1  burst request valid
req_ready  out  1  request accepted when req_valid&req_ready
req_write  in  1  1=write burst, 0=read burst
req_addr  in  DATA_ADDR_WIDTH  byte address of burst
wdata_valid  in  1  write beat valid
wdata_ready  out  1  write beat accepted when wdata_valid&wdata_ready
wdata  in  DATA_WIDTH  write beat data
wdata_last  in  1  master marks final write beat
rdata_valid  out  1  read beat valid
rdata_ready  in  1  read beat consumed when rdata_valid&rdata_ready
rdata  out  DATA_WIDTH  read beat data
rdata_last  out  1  final read beat marker
wr_done  out  1  one-cycle pulse after last write beat stored
proto_err  out  1  sticky protocol error flag

Behaviour:
- Reset: async assert forces state=IDLE. req_ready=0 during reset, 1 on first cycle after deassert. wdata_ready=0, rdata_valid=0, rdata=0, rdata_last=0, wr_done=0, proto_err=0, beat and latency counters=0. Memory array is not reset; contents persist.
- Reset mid-burst aborts the burst immediately. Write beats already stored remain in memory.
- Address mapping: word index = req_addr>>2. Low log2(burst length) index bits are cleared, so the burst is line-aligned. Index is taken modulo NUM_WORDS. req_addr[1:0] is ignored.
- Beat n of a burst accesses base+n. Index wraps modulo NUM_WORDS.
- FSM states: IDLE, RD_WAIT, RD_BURST, WR_BURST, WR_DONE.
- IDLE: req_ready=1. On handshake, latch base index and req_write, clear counters, deassert req_ready the next cycle.
  - Next state is WR_BURST if req_write=1, else RD_WAIT.
- RD_WAIT: counts READ_LATENCY cycles, then enters RD_BURST. First rdata_valid appears exactly READ_LATENCY+1 cycles after the accept edge.
- RD_BURST:
  - rdata_valid=1, rdata=mem[base+beat].
  - rdata and rdata_valid hold stable while rdata_ready=0. There is no timeout.
  - On handshake, beat increments. rdata_last=1 iff beat==READ_BURST_LEN-1.
  - Handshake on the last beat returns to IDLE; req_ready=1 the following cycle.
- WR_BURST:
  - wdata_ready=1. Each handshake writes mem[base+beat]<=wdata and increments beat.
  - On the handshake with beat==WRITE_BURST_LEN-1, go to WR_DONE.
- WR_DONE: wr_done=1 for exactly one cycle, wdata_ready=0, then IDLE.
- proto_err sets and stays set until reset when either of these occurs:
  - wdata_last=1 on a non-final write beat.
  - wdata_last=0 on the final write beat.
- A protocol error does not alter the burst length or the data written.
- wdata_valid outside WR_BURST is ignored, with no error and no write.
- Read/write same-cycle hazard: a write to index k followed by a read burst covering k returns the new value. The write completes before the read is accepted.
- Single outstanding burst only; no reordering.
- Combinational outputs are allowed only for rdata from the registered index. All other outputs are registered or derived from the state register.

Test Plan:
- Reset, then idle: after sys_rst_n rises, req_ready=1, all other outputs 0. Assert sys_rst_n low mid-cycle (async) → outputs clear without a clock edge.
- Write burst at 0x40 with data 0x100..0x107, wdata_last on beat 7 → wdata_ready high 8 cycles, wr_done pulses once, proto_err=0. Then read at 0x5C (aligned to index 16) → beats 0x100..0x107, rdata_last only on the 8th, first beat 5 cycles after accept.
- Read backpressure: toggle rdata_ready 0/1 every cycle during a read at index 16 → each beat is held stable until consumed, 8 distinct beats delivered in order, completes in 16 beat cycles.
- Wrap-around: NUM_WORDS=1024, write burst at byte 0xFE0 (index 1016) with data 0xA0..0xA7 → indices 1016..1023 written. Read at 0x1FE0 aliases to index 1016 → same data returned.
- Protocol error: write burst with wdata_last asserted on beat 3 → proto_err=1 from the next cycle, all 8 beats still stored, wr_done still pulses. proto_err stays 1 until reset.
- Reset mid-read: assert sys_rst_n low during beat 2 of a read → rdata_valid=0 immediately. After release, req_ready=1 and a new read returns correct data; memory contents are unchanged.
